control_fetch: RTL and testbench

Fetch sequencer for the 8-bit RISC core. Owns the program counter and drives the address of the combinational instruction ROM (256 × 16-bit). Captures each fetched word into an instruction register and presents it to the decoder over a valid/ready handshake. Handles jump redirects, and stops on the halt word 16'hFFFF, which is also the ROM's value for every unprogrammed address.

---
 rtl/pkg_risc8.sv | 16 +
 rtl/control_fetch.sv | 125 ++++++++++++
 tb/tb_control_fetch.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_risc8.sv
// Shared definitions for the 8-bit RISC core: datapath widths, the halt word
// and the fetch sequencer state encoding.
package pkg_risc8;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

endpackage

// File: rtl/control_fetch.sv
// Fetch sequencer: owns the PC, addresses the instruction ROM and hands words to
// the decoder over valid/ready. Optional delivered-instruction counter under FETCH_CNT_EN.
module control_fetch
   import pkg_risc8::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 8'd0
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [PC_W-1:0]    instr_addr,
   input  logic [INSTR_W-1:0] instr_data,
   output logic [INSTR_W-1:0] ir,
   output logic [PC_W-1:0]    ir_pc,
   output logic               ir_valid,
   input  logic               ir_ready,
   input  logic               jump_en,
   input  logic [PC_W-1:0]    jump_addr,
   output logic               busy,
   output logic               halted
`ifdef FETCH_CNT_EN
   ,
   output logic [15:0]        fetch_count
`endif
);

   // Handshake: ir/ir_pc are offered while ir_valid is high and must not change
   // until the cycle ir_ready is also high; that edge consumes the word.
   state_t               r_state;
   logic [PC_W-1:0]      r_pc;
   logic [INSTR_W-1:0]   r_ir;
   logic [PC_W-1:0]      r_ir_pc;
   logic                 r_ir_valid;
   logic                 r_busy;
   logic                 r_halted;

   logic w_load;
   logic w_halt_word;
   logic w_handshake;

   assign w_load      = !r_ir_valid || ir_ready;
   assign w_halt_word = (instr_data == HALT_WORD);
   assign w_handshake = r_ir_valid && ir_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_ir_pc    <= '0;
         r_ir_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_pc    <= RESET_PC;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               // A jump flushes whatever is pending; the target is fetched next cycle.
               if (jump_en) begin
                  r_pc       <= jump_addr;
                  r_ir_valid <= 1'b0;
               end else if (w_load) begin
                  if (w_halt_word) begin
                     r_ir_valid <= 1'b0;
                     r_state    <= HALT;
                     r_busy     <= 1'b0;
                     r_halted   <= 1'b1;
                  end else begin
                     r_ir       <= instr_data;
                     r_ir_pc    <= r_pc;
                     r_ir_valid <= 1'b1;
                     r_pc       <= r_pc + 8'd1;
                  end
               end
            end
            HALT: begin
               if (jump_en || start) begin
                  r_state  <= RUN;
                  r_pc     <= jump_en ? jump_addr : RESET_PC;
                  r_busy   <= 1'b1;
                  r_halted <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_ir_valid <= 1'b0;
               r_busy     <= 1'b0;
               r_halted   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_CNT_EN
   logic [15:0] r_fetch_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= '0;
      end else if (w_handshake && (r_fetch_count != 16'hFFFF)) begin
         r_fetch_count <= r_fetch_count + 16'd1;
      end
   end

   assign fetch_count = r_fetch_count;
`else
   logic w_unused_handshake;
   assign w_unused_handshake = w_handshake;
`endif

   assign instr_addr = r_pc;
   assign ir         = r_ir;
   assign ir_pc      = r_ir_pc;
   assign ir_valid   = r_ir_valid;
   assign busy       = r_busy;
   assign halted     = r_halted;

endmodule

// File: tb/tb_control_fetch.sv
// Self-checking bench for control_fetch: directed scenarios plus a randomized run
// scored against a ROM-walk stream model. Build with FETCH_CNT_EN to cover the counter.
module tb_control_fetch;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  instr_addr;
   logic [15:0] instr_data;
   logic [15:0] ir;
   logic [7:0]  ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        jump_en;
   logic [7:0]  jump_addr;
   logic        busy;
   logic        halted;
`ifdef FETCH_CNT_EN
   logic [15:0] fetch_count;
`endif

   logic [15:0] rom [256];
   logic [15:0] prog [7];
   logic [23:0] exp_q [$];

   int n_checks;
   int n_fail;

   assign instr_data = rom[instr_addr];

   control_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .ir         (ir),
      .ir_pc      (ir_pc),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready),
      .jump_en    (jump_en),
      .jump_addr  (jump_addr),
      .busy       (busy),
      .halted     (halted)
`ifdef FETCH_CNT_EN
      ,
      .fetch_count(fetch_count)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // driver helpers
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_prog_rom;
      for (int a = 0; a < 256; a++) rom[a] = 16'hFFFF;
      for (int k = 0; k < 7; k++) rom[k] = prog[k];
   endtask

   // Expected delivery stream: every word from addr onward until the first halt word.
   task automatic build_stream(input logic [7:0] addr);
      logic [7:0] a;
      exp_q.delete();
      a = addr;
      for (int i = 0; i < 256; i++) begin
         if (rom[a] == 16'hFFFF) break;
         exp_q.push_back({a, rom[a]});
         a = a + 8'd1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (instr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", instr_addr); end
      n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %0h expected 0", ir); end
      n_checks++; if (ir_pc !== 8'h00) begin n_fail++; $display("FAIL reset_ir_pc: got %0h expected 0", ir_pc); end
      n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ir_valid); end
      n_checks++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_state: got busy=%b halted=%b expected 0 0", busy, halted); end
`ifdef FETCH_CNT_EN
      n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
`endif
      rst = 1'b0;
      // jump in IDLE must be ignored
      jump_en = 1'b1; jump_addr = 8'd9;
      tick;
      jump_en = 1'b0;
      n_checks++; if (busy !== 1'b0 || instr_addr !== 8'd0) begin n_fail++; $display("FAIL idle_jump: got busy=%b addr=%0h expected 0 0", busy, instr_addr); end
   endtask

   task automatic test_program;
      load_prog_rom();
      start = 1'b1;
      tick;
      start = 1'b0;
      n_checks++; if (busy !== 1'b1 || ir_valid !== 1'b0 || instr_addr !== 8'd0) begin n_fail++; $display("FAIL start_state: got busy=%b valid=%b addr=%0h expected 1 0 0", busy, ir_valid, instr_addr); end
      ir_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick;
         n_checks++;
         if (ir_valid !== 1'b1 || ir !== prog[k] || ir_pc !== 8'(k)) begin
            n_fail++; $display("FAIL prog_seq%0d: got v=%b ir=%h pc=%0d expected v=1 ir=%h pc=%0d", k, ir_valid, ir, ir_pc, prog[k], k);
         end
      end
      tick;
      n_checks++; if (halted !== 1'b1 || busy !== 1'b0 || ir_valid !== 1'b0 || instr_addr !== 8'd7) begin n_fail++; $display("FAIL prog_halt: got h=%b b=%b v=%b addr=%0d expected 1 0 0 7", halted, busy, ir_valid, instr_addr); end
      for (int k = 0; k < 3; k++) begin
         tick;
         n_checks++; if (ir_valid !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got v=%b h=%b expected 0 1", ir_valid, halted); end
      end
   endtask

   task automatic test_backpressure;
      start = 1'b1;
      tick;
      start = 1'b0;
      ir_ready = 1'b1;
      tick;
      tick;
      n_checks++; if (ir !== 16'h134B) begin n_fail++; $display("FAIL bp_setup: got %h expected 134b", ir); end
      ir_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         n_checks++;
         if (ir_valid !== 1'b1 || ir !== 16'h134B || ir_pc !== 8'd1 || instr_addr !== 8'd2) begin
            n_fail++; $display("FAIL bp_hold%0d: got v=%b ir=%h pc=%0d addr=%0d expected 1 134b 1 2", k, ir_valid, ir, ir_pc, instr_addr);
         end
      end
      ir_ready = 1'b1;
      tick;
      n_checks++; if (ir !== 16'h256C || ir_pc !== 8'd2) begin n_fail++; $display("FAIL bp_resume: got ir=%h pc=%0d expected 256c 2", ir, ir_pc); end
   endtask

   task automatic test_jump_flush;
      ir_ready = 1'b0;
      jump_en = 1'b1; jump_addr = 8'd5;
      tick;
      jump_en = 1'b0;
      n_checks++; if (ir_valid !== 1'b0 || instr_addr !== 8'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL jump_flush: got v=%b addr=%0d b=%b expected 0 5 1", ir_valid, instr_addr, busy); end
      ir_ready = 1'b1;
      tick;
      n_checks++; if (ir_valid !== 1'b1 || ir !== 16'h49AE || ir_pc !== 8'd5) begin n_fail++; $display("FAIL jump_target: got v=%b ir=%h pc=%0d expected 1 49ae 5", ir_valid, ir, ir_pc); end
      tick;
      n_checks++; if (ir !== 16'h6BAB || ir_pc !== 8'd6) begin n_fail++; $display("FAIL jump_next: got ir=%h pc=%0d expected 6bab 6", ir, ir_pc); end
      tick;
      n_checks++; if (halted !== 1'b1 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL jump_halt: got h=%b v=%b expected 1 0", halted, ir_valid); end
   endtask

   task automatic test_halt_jump_start;
      bit done;
      jump_en = 1'b1; start = 1'b1; jump_addr = 8'd3;
      tick;
      jump_en = 1'b0; start = 1'b0;
      n_checks++; if (busy !== 1'b1 || halted !== 1'b0 || instr_addr !== 8'd3) begin n_fail++; $display("FAIL hjs_state: got b=%b h=%b addr=%0d expected 1 0 3", busy, halted, instr_addr); end
      tick;
      n_checks++; if (ir_valid !== 1'b1 || ir !== 16'h378D || ir_pc !== 8'd3) begin n_fail++; $display("FAIL hjs_first: got v=%b ir=%h pc=%0d expected 1 378d 3", ir_valid, ir, ir_pc); end
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         tick;
         if (halted) done = 1'b1;
      end
      n_checks++; if (!done) begin n_fail++; $display("FAIL hjs_drain: got halted=0 after 20 cycles expected 1"); end
   endtask

   task automatic test_wrap;
      logic [7:0] pcs [4];
      pcs[0] = 8'd254; pcs[1] = 8'd255; pcs[2] = 8'd0; pcs[3] = 8'd1;
      for (int a = 0; a < 256; a++) rom[a] = 16'h1000;
      rom[2] = 16'hFFFF;
      ir_ready = 1'b0;
      jump_en = 1'b1; jump_addr = 8'd254;
      tick;
      jump_en = 1'b0;
      ir_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         n_checks++;
         if (ir_valid !== 1'b1 || ir !== 16'h1000 || ir_pc !== pcs[k]) begin
            n_fail++; $display("FAIL wrap%0d: got v=%b ir=%h pc=%0d expected 1 1000 %0d", k, ir_valid, ir, ir_pc, pcs[k]);
         end
      end
      tick;
      n_checks++; if (halted !== 1'b1 || instr_addr !== 8'd2) begin n_fail++; $display("FAIL wrap_halt: got h=%b addr=%0d expected 1 2", halted, instr_addr); end
   endtask

   task automatic test_random;
      logic [23:0] e;
      logic [23:0] prev;
      logic [7:0]  tgt;
      logic [15:0] exp_cnt;
      bit          held;
      bit          done;
      for (int a = 0; a < 256; a++)
         rom[a] = ($urandom_range(0, 11) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
      rom[255] = 16'hFFFF;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      exp_cnt = 16'd0;
      for (int r = 0; r < 20; r++) begin
         tgt = 8'($urandom_range(0, 255));
         if (halted && $urandom_range(0, 1) == 1) begin
            jump_en = 1'b1; jump_addr = tgt; start = ($urandom_range(0, 1) == 1);
            build_stream(tgt);
         end else begin
            start = 1'b1;
            build_stream(8'd0);
         end
         tick;
         jump_en = 1'b0; start = 1'b0;
         done = 1'b0;
         for (int c = 0; c < 2000 && !done; c++) begin
            ir_ready = ($urandom_range(0, 3) != 0);
            jump_en  = ($urandom_range(0, 15) == 0);
            jump_addr = 8'($urandom_range(0, 255));
            if (ir_valid && ir_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL rand_extra: got ir=%h pc=%0d expected no delivery", ir, ir_pc);
               end else begin
                  e = exp_q.pop_front();
                  if ({ir_pc, ir} !== e) begin n_fail++; $display("FAIL rand_word: got pc=%0d ir=%h expected pc=%0d ir=%h", ir_pc, ir, e[23:16], e[15:0]); end
               end
               if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
            if (jump_en) build_stream(jump_addr);
            held = ir_valid && !ir_ready && !jump_en;
            prev = {ir_pc, ir};
            tick;
            jump_en = 1'b0;
            if (held) begin
               n_checks++; if (ir_valid !== 1'b1 || {ir_pc, ir} !== prev) begin n_fail++; $display("FAIL rand_stable: got v=%b pc=%0d ir=%h expected 1 pc=%0d ir=%h", ir_valid, ir_pc, ir, prev[23:16], prev[15:0]); end
            end
            if (halted) begin
               n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_early_halt: got %0d words undelivered expected 0", exp_q.size()); end
               done = 1'b1;
            end
         end
         if (!done) begin
            n_checks++; n_fail++; $display("FAIL rand_timeout: got no halt in round %0d expected halt", r);
         end
`ifdef FETCH_CNT_EN
         n_checks++; if (fetch_count !== exp_cnt) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", fetch_count, exp_cnt); end
`endif
      end
   endtask

   task automatic test_mid_reset;
      load_prog_rom();
      start = 1'b1;
      tick;
      start = 1'b0;
      ir_ready = 1'b1;
      repeat (3) tick;
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (instr_addr !== 8'd0 || ir !== 16'h0 || ir_pc !== 8'h0) begin n_fail++; $display("FAIL mid_rst_regs: got addr=%0d ir=%h pc=%0d expected 0 0 0", instr_addr, ir, ir_pc); end
      n_checks++; if (ir_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got v=%b b=%b h=%b expected 0 0 0", ir_valid, busy, halted); end
`ifdef FETCH_CNT_EN
      n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d expected 0", fetch_count); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick;
      n_checks++; if (busy !== 1'b0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got b=%b v=%b expected 0 0", busy, ir_valid); end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b0; start = 1'b0; ir_ready = 1'b0; jump_en = 1'b0; jump_addr = 8'd0;
      prog[0] = 16'h012A; prog[1] = 16'h134B; prog[2] = 16'h256C; prog[3] = 16'h378D;
      prog[4] = 16'h5999; prog[5] = 16'h49AE; prog[6] = 16'h6BAB;
      load_prog_rom();
      test_reset();
      test_program();
      test_backpressure();
      test_jump_flush();
      test_halt_jump_start();
      test_wrap();
      test_random();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
